// File: rtl/riscboy_ppu_lcd_pkg.sv
// rtl/riscboy_ppu_lcd_pkg.sv - shared types and helpers for the LCD transmit engine
package riscboy_ppu_lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    STALL,
    HOLD
  } lcd_state_t;

  localparam int W_SHAMT = 3;  // width of the log2 lane-count field
  localparam int W_BEAT  = 8;  // beat counter width, covers words up to 128 bits

  function automatic int clamp_lg(input logic [W_SHAMT-1:0] lg, input int lg_max);
    return (int'(lg) > lg_max) ? lg_max : int'(lg);
  endfunction

endpackage

// File: rtl/riscboy_sync_fifo.sv
// rtl/riscboy_sync_fifo.sv - single-clock show-ahead FIFO with flush
module riscboy_sync_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/riscboy_ppu_lcd_shifter.sv
// rtl/riscboy_ppu_lcd_shifter.sv - FIFO-fed multi-lane LCD serialiser with SCK divider and CS/DC framing
module riscboy_ppu_lcd_shifter
  import riscboy_ppu_lcd_pkg::*;
#(
  parameter int W_DATA     = 16,
  parameter int W_BUS      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int W_DIV      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [W_DATA-1:0] i_in_data,
  input  logic              i_in_dc,
  input  logic              i_in_last,
  input  logic              i_cfg_en,
  input  logic [2:0]        i_cfg_lanes,
  input  logic              i_cfg_half,
  input  logic [W_DIV-1:0]  i_cfg_div,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_underrun,
  input  logic              i_underrun_clr,
  output logic              o_lcd_sck,
  output logic              o_lcd_cs_n,
  output logic              o_lcd_dc,
  output logic [W_BUS-1:0]  o_lcd_dat
);

  localparam int LG_MAX = $clog2(W_BUS);
  localparam int W_FIFO = W_DATA + 2;

  lcd_state_t          r_state;
  lcd_state_t          w_state_nxt;
  logic [W_DIV-1:0]    r_div;
  logic [W_DIV-1:0]    r_div_cnt;
  logic [W_DATA-1:0]   r_sr;
  logic [W_SHAMT-1:0]  r_lg;
  logic [W_BEAT-1:0]   r_beat_left;
  logic                r_last;
  logic                r_sck;
  logic                r_cs_n;
  logic                r_dc;
  logic                r_underrun;
  logic [W_BUS-1:0]    r_dat;

  logic                w_push;
  logic                w_flush;
  logic                w_empty;
  logic                w_full;
  logic                w_tick;
  logic                w_load;
  logic                w_shift;
  logic                w_sck_rise;
  logic                w_sck_fall;
  logic                w_cs_rel;
  logic                w_set_underrun;
  logic [W_FIFO-1:0]   w_rdata;
  logic [W_SHAMT-1:0]  w_lg;
  logic [W_BEAT-1:0]   w_beats;
  logic [W_DATA-1:0]   w_load_sr;
  logic [W_DATA-1:0]   w_next_sr;

  // Top (1<<lg) bits of the shift register, lane 0 holding the least significant of them.
  function automatic logic [W_BUS-1:0] beat_of(input logic [W_DATA-1:0] sr,
                                               input logic [W_SHAMT-1:0] lg);
    return W_BUS'(sr >> (W_DATA - (1 << lg)));
  endfunction

  assign o_in_ready = !i_rst && !w_full;
  assign w_push     = i_in_valid && o_in_ready;
  assign w_flush    = i_flush && (r_state == IDLE);
  assign o_busy     = (r_state != IDLE) || !w_empty;
  assign w_tick     = (r_state != IDLE) && (r_div_cnt == r_div);

  riscboy_sync_fifo #(.W(W_FIFO), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata ({i_in_last, i_in_dc, i_in_data}),
    .i_pop   (w_load),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_lg      = W_SHAMT'(clamp_lg(i_cfg_lanes, LG_MAX));
  assign w_load_sr = i_cfg_half ? {w_rdata[W_DATA/2-1:0], {(W_DATA/2){1'b0}}} : w_rdata[W_DATA-1:0];
  assign w_next_sr = r_sr << (1 << r_lg);

  always_comb begin
    w_beats = W_BEAT'((i_cfg_half ? W_DATA / 2 : W_DATA) >> w_lg);
    if (w_beats == '0) w_beats = W_BEAT'(1);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_shift        = 1'b0;
    w_sck_rise     = 1'b0;
    w_sck_fall     = 1'b0;
    w_cs_rel       = 1'b0;
    w_set_underrun = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_cfg_en && !w_empty && !i_flush) begin
          w_load      = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: if (w_tick) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_tick) begin
          if (!r_sck) begin
            w_sck_rise = 1'b1;
          end else begin
            w_sck_fall = 1'b1;
            if (r_beat_left != '0) w_shift = 1'b1;
            else if (r_last || !i_cfg_en) w_state_nxt = HOLD;
            else if (!w_empty) w_load = 1'b1;
            else begin
              w_state_nxt    = STALL;
              w_set_underrun = 1'b1;
            end
          end
        end
      end
      STALL: begin
        if (w_tick) begin
          if (!i_cfg_en) w_state_nxt = HOLD;
          else if (!w_empty) begin
            w_load      = 1'b1;
            w_state_nxt = SHIFT;
          end
        end
      end
      // First tick releases CS, second tick returns to IDLE: guarantees one tick of CS high.
      HOLD: begin
        if (w_tick) begin
          if (!r_cs_n) w_cs_rel = 1'b1;
          else w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_sr        <= '0;
      r_lg        <= '0;
      r_beat_left <= '0;
      r_last      <= 1'b0;
      r_sck       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_dc        <= 1'b0;
      r_underrun  <= 1'b0;
      r_dat       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE || w_tick) r_div_cnt <= '0;
      else r_div_cnt <= r_div_cnt + 1'b1;
      if (w_load) begin
        r_sr        <= w_load_sr;
        r_lg        <= w_lg;
        r_div       <= i_cfg_div;
        r_beat_left <= w_beats - 1'b1;
        r_last      <= w_rdata[W_DATA+1];
        r_dc        <= w_rdata[W_DATA];
        r_dat       <= beat_of(w_load_sr, w_lg);
        r_cs_n      <= 1'b0;
      end else if (w_shift) begin
        r_sr        <= w_next_sr;
        r_dat       <= beat_of(w_next_sr, r_lg);
        r_beat_left <= r_beat_left - 1'b1;
      end
      if (w_cs_rel) r_cs_n <= 1'b1;
      if (w_sck_rise) r_sck <= 1'b1;
      else if (w_sck_fall) r_sck <= 1'b0;
      if (w_set_underrun) r_underrun <= 1'b1;
      else if (i_underrun_clr) r_underrun <= 1'b0;
    end
  end

  assign o_underrun = r_underrun;
  assign o_lcd_sck  = r_sck;
  assign o_lcd_cs_n = r_cs_n;
  assign o_lcd_dc   = r_dc;
  assign o_lcd_dat  = r_dat;

endmodule

// File: tb/tb_riscboy_ppu_lcd_shifter.sv
// tb/tb_riscboy_ppu_lcd_shifter.sv - directed and randomized bench for the LCD shifter
module tb_riscboy_ppu_lcd_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_dc, in_last, cfg_en, cfg_half, flush, underrun_clr;
  logic [15:0] in_data;
  logic [2:0]  cfg_lanes;
  logic [3:0]  cfg_div;
  logic        in_ready, busy, underrun, lcd_sck, lcd_cs_n, lcd_dc;
  logic [7:0]  lcd_dat;

  always #5 clk = ~clk;

  riscboy_ppu_lcd_shifter #(.W_DATA(16), .W_BUS(8), .FIFO_DEPTH(8), .W_DIV(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_data      (in_data),
    .i_in_dc        (in_dc),
    .i_in_last      (in_last),
    .i_cfg_en       (cfg_en),
    .i_cfg_lanes    (cfg_lanes),
    .i_cfg_half     (cfg_half),
    .i_cfg_div      (cfg_div),
    .i_flush        (flush),
    .o_busy         (busy),
    .o_underrun     (underrun),
    .i_underrun_clr (underrun_clr),
    .o_lcd_sck      (lcd_sck),
    .o_lcd_cs_n     (lcd_cs_n),
    .o_lcd_dc       (lcd_dc),
    .o_lcd_dat      (lcd_dat)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [8:0] beats[$];
  logic [8:0] exp_q[$];
  int rise_cnt, frames, bad_rise, min_gap, max_gap, min_hi, max_hi, last_rise, tmp;
  bit has_rise;
  logic prev_sck = 1'b0;
  logic prev_cs = 1'b1;

  // Pin monitor: captures {dc, dat} at every SCK rise plus timing and framing statistics.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!prev_sck && lcd_sck) begin
      beats.push_back({lcd_dc, lcd_dat});
      rise_cnt = rise_cnt + 1;
      if (lcd_cs_n) bad_rise = bad_rise + 1;
      if (has_rise) begin
        tmp = cyc - last_rise;
        if (tmp < min_gap) min_gap = tmp;
        if (tmp > max_gap) max_gap = tmp;
      end
      has_rise  = 1'b1;
      last_rise = cyc;
    end
    if (prev_sck && !lcd_sck && has_rise) begin
      tmp = cyc - last_rise;
      if (tmp < min_hi) min_hi = tmp;
      if (tmp > max_hi) max_hi = tmp;
    end
    if (prev_cs && !lcd_cs_n) frames = frames + 1;
    prev_sck = lcd_sck;
    prev_cs  = lcd_cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    @(posedge clk);
    #1;
    beats.delete();
    exp_q.delete();
    rise_cnt = 0; frames = 0; bad_rise = 0; has_rise = 1'b0;
    min_gap = 1000000; max_gap = 0; min_hi = 1000000; max_hi = 0;
  endtask

  task automatic push(input logic [15:0] d, input logic dc, input logic last);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_dc = dc; in_last = last;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || !lcd_cs_n) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", {31'b0, busy}, 0);
  endtask

  // Reference: a word is bits/L beats, each the next L bits of the word MSB first.
  task automatic expect_word(input logic [15:0] w, input logic dc, input int lanes_cfg, input logic half);
    int lg, l, bits, nb;
    logic [15:0] wv;
    lg   = (lanes_cfg > 3) ? 3 : lanes_cfg;
    l    = 1 << lg;
    bits = half ? 8 : 16;
    wv   = half ? (w & 16'h00FF) : w;
    nb   = bits / l;
    if (nb < 1) nb = 1;
    for (int b = 0; b < nb; b++)
      exp_q.push_back({dc, 8'((int'(wv) >> (bits - l * (b + 1))) & ((1 << l) - 1))});
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_count"}, beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) check(tag, {23'b0, beats[i]}, {23'b0, exp_q[i]});
    exp_q.delete();
  endtask

  initial begin
    int nw, lanes_r;
    logic half_r, dcb;
    logic [3:0] div_r;
    logic [15:0] d;
    in_valid = 0; in_data = 0; in_dc = 0; in_last = 0; cfg_en = 0; cfg_lanes = 0;
    cfg_half = 0; cfg_div = 0; flush = 0; underrun_clr = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sck", {31'b0, lcd_sck}, 0);
    check("rst_cs_n", {31'b0, lcd_cs_n}, 1);
    check("rst_dc", {31'b0, lcd_dc}, 0);
    check("rst_dat", {24'b0, lcd_dat}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_underrun", {31'b0, underrun}, 0);
    check("rst_ready_after", {31'b0, in_ready}, 1);

    // single lane, single framed word
    mon_clear();
    cfg_en = 1; cfg_lanes = 0; cfg_div = 0; cfg_half = 0;
    push(16'hA5C3, 1'b1, 1'b1);
    wait_idle(200);
    expect_word(16'hA5C3, 1'b1, 0, 1'b0);
    compare_beats("t1_beat");
    check("t1_rises", rise_cnt, 16);
    check("t1_frames", frames, 1);
    check("t1_bad_rise", bad_rise, 0);

    // 8 lanes, two back-to-back words, DC changes with second word
    cfg_en = 0; cfg_lanes = 3;
    push(16'h1234, 1'b0, 1'b0);
    push(16'h5678, 1'b1, 1'b1);
    mon_clear();
    cfg_en = 1;
    wait_idle(200);
    expect_word(16'h1234, 1'b0, 3, 1'b0);
    expect_word(16'h5678, 1'b1, 3, 1'b0);
    compare_beats("t2_beat");
    check("t2_rises", rise_cnt, 4);
    check("t2_min_gap", min_gap, 2);
    check("t2_max_gap", max_gap, 2);

    // divider 3, half word on one lane
    mon_clear();
    cfg_div = 3; cfg_half = 1; cfg_lanes = 0;
    push(16'hBEEF, 1'b1, 1'b1);
    wait_idle(400);
    expect_word(16'hBEEF, 1'b1, 0, 1'b1);
    compare_beats("t3_beat");
    check("t3_min_hi", min_hi, 4);
    check("t3_max_hi", max_hi, 4);
    check("t3_min_gap", min_gap, 8);
    check("t3_max_gap", max_gap, 8);

    // underrun and resume
    mon_clear();
    cfg_div = 0; cfg_half = 0; cfg_lanes = 0;
    push(16'h00FF, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    check("t4_stall_sck", {31'b0, lcd_sck}, 0);
    check("t4_stall_cs", {31'b0, lcd_cs_n}, 0);
    check("t4_underrun", {31'b0, underrun}, 1);
    check("t4_busy", {31'b0, busy}, 1);
    push(16'h8001, 1'b1, 1'b1);
    wait_idle(200);
    expect_word(16'h00FF, 1'b0, 0, 1'b0);
    expect_word(16'h8001, 1'b1, 0, 1'b0);
    compare_beats("t4_beat");
    check("t4_frames", frames, 1);
    check("t4_sticky", {31'b0, underrun}, 1);
    @(negedge clk); underrun_clr = 1;
    @(negedge clk); underrun_clr = 0;
    check("t4_clr", {31'b0, underrun}, 0);

    // fill with engine disabled, then flush
    cfg_en = 0;
    mon_clear();
    for (int i = 0; i < 8; i++) push(16'($urandom), 1'b1, 1'b0);
    @(negedge clk);
    check("t5_full_ready", {31'b0, in_ready}, 0);
    check("t5_full_busy", {31'b0, busy}, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("t5_flush_busy", {31'b0, busy}, 0);
    check("t5_flush_ready", {31'b0, in_ready}, 1);
    cfg_en = 1;
    repeat (10) @(negedge clk);
    check("t5_no_sck", rise_cnt, 0);
    check("t5_no_frame", frames, 0);

    // randomized transfers against the reference model
    for (int t = 0; t < 8; t++) begin
      nw = $urandom_range(1, 4);
      lanes_r = $urandom_range(0, 7);
      half_r = 1'($urandom_range(0, 1));
      div_r = 4'($urandom_range(0, 2));
      cfg_lanes = 3'(lanes_r); cfg_half = half_r; cfg_div = div_r; cfg_en = 1;
      mon_clear();
      for (int w = 0; w < nw; w++) begin
        d = 16'($urandom);
        dcb = 1'($urandom_range(0, 1));
        push(d, dcb, w == nw - 1);
        expect_word(d, dcb, lanes_r, half_r);
      end
      wait_idle(2000);
      compare_beats("rnd_beat");
      check("rnd_frames", frames, 1);
      check("rnd_bad_rise", bad_rise, 0);
    end

    // reset mid-transfer with underrun set and FIFO occupied
    @(negedge clk); underrun_clr = 1;
    @(negedge clk); underrun_clr = 0;
    cfg_lanes = 0; cfg_half = 0; cfg_div = 0;
    push(16'hFFFF, 1'b1, 1'b0);
    repeat (45) @(negedge clk);
    check("t6_underrun", {31'b0, underrun}, 1);
    push(16'hFFFF, 1'b1, 1'b1);
    push(16'hFFFF, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    check("t6_mid_cs", {31'b0, lcd_cs_n}, 0);
    rst = 1'b1;
    #1;
    check("t6_rst_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    #1;
    check("t6_sck", {31'b0, lcd_sck}, 0);
    check("t6_cs_n", {31'b0, lcd_cs_n}, 1);
    check("t6_dc", {31'b0, lcd_dc}, 0);
    check("t6_dat", {24'b0, lcd_dat}, 0);
    check("t6_busy", {31'b0, busy}, 0);
    check("t6_underrun_clr", {31'b0, underrun}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_after_busy", {31'b0, busy}, 0);
    check("t6_after_cs", {31'b0, lcd_cs_n}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
